muldiv_unit: RTL

- Iterative multi-cycle multiply/divide responder for the EX stage.
- Replaces the single-cycle combinational MUL/DIV path of the ALU for R-type func MUL (6'b000010) and DIV (6'b000001).
- The EX control logic is the initiator: it issues a start/operand request and stalls the pipeline until the done pulse, then takes result and flag exactly as it takes them from the ALU.
- Flag encoding is shared with the ALU: 3'b000 not active, 3'b010 exception, 3'b011 overflow/underflow.

---
 rtl/muldiv_unit_if.sv | 18 +
 rtl/muldiv_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/completion bundle between EX control (master) and the mul/div unit (slave)
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [5:0]       func;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic [2:0]       flag;
  modport master(output start, func, data_a, data_b, abort,
                 input ready, busy, done, result, remainder, flag);
  modport slave(input start, func, data_a, data_b, abort,
                output ready, busy, done, result, remainder, flag);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add MUL / restoring DIV responder; define MULDIV_EARLY_EXIT_EN for data-dependent MUL latency
module muldiv_unit #(parameter int WIDTH = 32) (
  input logic         clock,
  input logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [5:0] F_MUL = 6'b000010;
  localparam logic [5:0] F_DIV = 6'b000001;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t             state;
  // MUL: acc = running product, mcand = shifted multiplicand, mplier = remaining multiplier bits.
  // DIV: acc low word = partial remainder, mcand low word = divisor, mplier = dividend shifting into quotient.
  logic [2*WIDTH-1:0] acc, mcand, acc_n;
  logic [WIDTH-1:0]   mplier, result, remainder, r_n, q_n;
  logic [WIDTH:0]     r_sh, diff;
  logic [CW-1:0]      cnt;
  logic [2:0]         flag;
  logic               ready, done, mul_last, zero_mul;
  assign acc_n = acc + (mplier[0] ? mcand : '0);
  assign r_sh  = {acc[WIDTH-1:0], mplier[WIDTH-1]};
  assign diff  = r_sh - {1'b0, mcand[WIDTH-1:0]};
  assign r_n   = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_n   = {mplier[WIDTH-2:0], ~diff[WIDTH]};
`ifdef MULDIV_EARLY_EXIT_EN
  assign mul_last = mplier[WIDTH-1:1] == '0;
  assign zero_mul = bus.data_a == '0 || bus.data_b == '0;
`else
  assign mul_last = cnt == CW'(1);
  assign zero_mul = 1'b0;
`endif
  assign bus.ready     = ready;
  assign bus.busy      = ~ready;
  assign bus.done      = done;
  assign bus.result    = result;
  assign bus.remainder = remainder;
  assign bus.flag      = flag;
  // Control FSM and datapath; outputs are only written on the edge entering DONE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      result    <= '0;
      remainder <= '0;
      flag      <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start && !bus.abort && (bus.func == F_MUL || bus.func == F_DIV)) begin
          acc    <= '0;
          cnt    <= CW'(WIDTH);
          ready  <= 1'b0;
          mcand  <= {{WIDTH{1'b0}}, bus.func == F_MUL ? bus.data_a : bus.data_b};
          mplier <= bus.func == F_MUL ? bus.data_b : bus.data_a;
          if (bus.func == F_MUL ? zero_mul : bus.data_b == '0) begin
            state     <= DONE;
            done      <= 1'b1;
            result    <= '0;
            remainder <= '0;
            flag      <= bus.func == F_MUL ? 3'b000 : 3'b010;
          end else begin
            state <= bus.func == F_MUL ? MUL : DIV;
          end
        end
        MUL: if (bus.abort) begin
          state <= IDLE;
          ready <= 1'b1;
        end else begin
          acc    <= acc_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (mul_last) begin
            state     <= DONE;
            done      <= 1'b1;
            result    <= acc_n[WIDTH-1:0];
            remainder <= '0;
            flag      <= acc_n[2*WIDTH-1:WIDTH] != '0 ? 3'b011 : 3'b000;
          end
        end
        DIV: if (bus.abort) begin
          state <= IDLE;
          ready <= 1'b1;
        end else begin
          acc[WIDTH-1:0] <= r_n;
          mplier         <= q_n;
          cnt            <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state     <= DONE;
            done      <= 1'b1;
            result    <= q_n;
            remainder <= r_n;
            flag      <= 3'b000;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
